// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode bit positions, word-length encoding and FSM states.
// Used by both the SPI master core and the SPI slave.
package spi_pkg;

  localparam int SPI_DATA_W = 32;
  localparam int CPOL_BIT   = 1;
  localparam int CPHA_BIT   = 0;

  typedef enum logic [1:0] {
    WL_8  = 2'b00,
    WL_16 = 2'b01,
    WL_24 = 2'b10,
    WL_32 = 2'b11
  } word_len_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // Number of bits per word for a word_len code: 8, 16, 24 or 32.
  function automatic logic [5:0] word_bits(input logic [1:0] wl);
    return {1'b0, wl, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with a history flop
// providing single-cycle rise/fall strobes on the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples SCLK/CS/MOSI in the GCLK domain, deserializes MOSI words
// and serializes tx words onto MISO MSB first, with back-to-back words per CS.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              GCLK,
  input  logic              RST_N,
  input  logic [1:0]        spi_mode_i,
  input  logic [1:0]        word_len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_load_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              frame_err_o,
  input  logic              SCLK_i,
  input  logic              CS_i,
  input  logic              MOSI_i,
  output logic              MISO_o,
  output logic              MISO_oe_o
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(GCLK), .rst_n(RST_N), .din(SCLK_i),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(GCLK), .rst_n(RST_N), .din(CS_i),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(GCLK), .rst_n(RST_N), .din(MOSI_i),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  spi_state_e        state;
  logic              cpol, cpha, reload_pend;
  logic [1:0]        wl;
  logic [5:0]        bit_cnt, cnt_next, nbits;
  logic [4:0]        msb;
  logic [DATA_W-1:0] tx_shift, rx_shift, rx_next;
  logic              active, lead_edge, trail_edge, sample_edge, shift_edge;
  logic              word_full, load_now, shift_now;

  function automatic logic [DATA_W-1:0] len_mask(input logic [5:0] n);
    len_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(n)) len_mask[i] = 1'b1;
    end
  endfunction

  assign nbits = word_bits(wl);
  assign msb   = {wl, 3'b111};

  always_comb begin
    active      = (state == ST_ACTIVE);
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = active & (cpha ? trail_edge : lead_edge);
    shift_edge  = active & (cpha ? lead_edge : trail_edge);
    cnt_next    = bit_cnt + 6'(sample_edge);
    rx_next     = sample_edge ? {rx_shift[DATA_W-2:0], mosi_lvl} : rx_shift;
    word_full   = active & (bit_cnt == nbits);
    // CPHA=0 reloads on the trailing edge after a word, in place of the shift
    load_now    = ((state == ST_IDLE) & cs_fall)
                | (word_full & cpha & ~cs_rise)
                | (shift_edge & ~cpha & reload_pend & ~cs_rise);
    shift_now   = shift_edge & ~cs_rise & ~(~cpha & reload_pend);
  end

  // datapath shifters
  always_ff @(posedge GCLK) begin
    if (load_now)       tx_shift <= tx_data_i;
    else if (shift_now) tx_shift <= tx_shift << 1;
    if (sample_edge)    rx_shift <= rx_next;
  end

  // control FSM and registered outputs
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      wl          <= 2'b00;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      tx_load_o   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      MISO_o      <= 1'b0;
      MISO_oe_o   <= 1'b0;
    end else begin
      tx_load_o   <= load_now;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state       <= ST_ACTIVE;
            cpol        <= spi_mode_i[CPOL_BIT];
            cpha        <= spi_mode_i[CPHA_BIT];
            wl          <= word_len_i;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            busy_o      <= 1'b1;
            MISO_oe_o   <= 1'b1;
            MISO_o      <= spi_mode_i[CPHA_BIT] ? 1'b0 : tx_data_i[{word_len_i, 3'b111}];
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state       <= ST_IDLE;
            busy_o      <= 1'b0;
            MISO_oe_o   <= 1'b0;
            MISO_o      <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            // a sample landing with CS rise still completes the word
            if (cnt_next == nbits) begin
              rx_data_o  <= rx_next & len_mask(nbits);
              rx_valid_o <= 1'b1;
            end else if (cnt_next != '0) begin
              frame_err_o <= 1'b1;
            end
          end else begin
            bit_cnt <= cnt_next;
            if (word_full) begin
              rx_data_o   <= rx_shift & len_mask(nbits);
              rx_valid_o  <= 1'b1;
              bit_cnt     <= '0;
              reload_pend <= ~cpha;
            end
            if (shift_edge) begin
              if (cpha) begin
                MISO_o <= tx_shift[msb];
              end else if (reload_pend) begin
                MISO_o      <= tx_data_i[msb];
                reload_pend <= 1'b0;
              end else begin
                MISO_o <= tx_shift[msb - 5'd1];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (target) end of the team's SPI link. It is the counterpart of the SPI master core, sharing the same spi_mode / word_len encodings.
- SCLK, CS and MOSI are oversampled in the GCLK domain.
- Received words are deserialized; transmit words are serialized onto MISO, MSB first.
- Intended for loop-back benches against the master and for FPGA designs acting as an SPI peripheral.

Parameters:
DATA_W, 32, maximum word width in bits; word_len_i selects 8/16/24/32 within it
SYNC_STAGES, 2, flip-flop stages on SCLK_i, CS_i and MOSI_i before edge detection

Ports:
GCLK  in  1  system clock; all logic synchronous to its rising edge
RST_N  in  1  asynchronous, active-low reset
spi_mode_i  in  2  [1]=CPOL, [0]=CPHA; latched at frame start
word_len_i  in  2  00=8, 01=16, 10=24, 11=32 bits; latched at frame start
tx_data_i  in  DATA_W  next word to send; low N bits used
tx_load_o  out  1  1-cycle pulse: tx_data_i captured into the shifter
rx_data_o  out  DATA_W  last complete received word, right-justified, upper bits 0
rx_valid_o  out  1  1-cycle pulse: rx_data_o updated
busy_o  out  1  high while a frame is active (synchronized CS low)
frame_err_o  out  1  1-cycle pulse: CS deasserted mid-word
SCLK_i  in  1  SPI clock from master
CS_i  in  1  chip select, active low
MOSI_i  in  1  serial data from master
MISO_o  out  1  serial data to master
MISO_oe_o  out  1  MISO output enable (high while frame active)

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Synchronizers reset to SCLK=0, CS=1, MOSI=0.
  - A reset mid-frame aborts the frame with no pulses.
- Synchronization: SYNC_STAGES flip-flops plus one history flip-flop per input.
  - Edges are detected on synchronized values.
  - Supported SCLK rate is at most GCLK/8.
- Edge definitions:
  - Leading edge = SCLK leaving CPOL level; trailing edge = SCLK returning to CPOL level.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- FSM IDLE:
  - MISO_o=0, MISO_oe_o=0, busy_o=0.
  - On synchronized CS falling edge: latch mode and N, load tx shifter from tx_data_i, pulse tx_load_o, clear bit_cnt, go to ACTIVE.
- FSM ACTIVE (busy_o=1, MISO_oe_o=1):
  - MISO_o output rule:
    - CPHA=0: MISO_o = shifter bit N-1 immediately after load.
    - CPHA=1: MISO_o is updated to shifter bit N-1 on each leading edge, then the shifter shifts.
  - On each sample edge: rx_shift <= {rx_shift, MOSI_sync}; bit_cnt++.
  - When bit_cnt reaches N:
    - Next cycle: rx_data_o <= rx_shift (N bits, zero-extended), rx_valid_o=1 for 1 cycle, bit_cnt=0.
    - Reload the tx shifter from tx_data_i and pulse tx_load_o. The reload point is:
      - CPHA=0: at the following trailing edge, replacing the shift, so the new MSB is on MISO before the next leading edge.
      - CPHA=1: at word completion.
  - Shift edges that are not reload points shift the tx shifter left by 1.
  - Multiple words per CS are supported back-to-back. There is no backpressure: rx_data_o is overwritten and tx_data_i is sampled whenever tx_load_o pulses.
  - On synchronized CS rising edge: return to IDLE.
    - If bit_cnt != 0, discard the partial word and pulse frame_err_o; no rx_valid_o.
- Simultaneous events:
  - A sample edge and CS rise detected in the same cycle: process the sample first. If it completes the word, rx_valid_o pulses and no frame_err_o is raised.
  - CS fall while ACTIVE cannot occur and needs no handling.
- Config inputs are ignored while ACTIVE.
- Latency: rx_valid_o asserts at most SYNC_STAGES+2 GCLK after the pin edge that completes the word.

Decomposition:
- Package spi_pkg:
  - spi_mode field positions (CPOL/CPHA).
  - word_len encoding and a function returning N from word_len.
  - FSM state typedef (IDLE, ACTIVE).
  - DATA_W default.
  - Shared with the master core.
- Sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall detector. Instantiated three times (SCLK, CS, MOSI; MOSI uses level only).

Test Plan:
- Mode 0, N=8, master sends 0xA5, tx_data_i=0x3C → rx_data_o=0x000000A5 with one rx_valid_o pulse; master receives 0x3C; one tx_load_o pulse at CS fall.
- Mode 3, N=32, master sends 0xDEADBEEF, tx_data_i=0x12345678 → rx_data_o=0xDEADBEEF; master receives 0x12345678; MISO_oe_o high only while CS low.
- Mode 1, N=16, two words in one CS: 0x1234 then 0xABCD; tx_data_i changed to 0x5555 after first tx_load_o → two rx_valid_o pulses (0x1234, 0xABCD); master gets 0xAAAA (initial tx_data_i) then 0x5555; no frame_err_o.
- Mode 2, N=24, CS released after 5 SCLKs → frame_err_o single pulse, no rx_valid_o, rx_data_o keeps previous value, busy_o falls, MISO_oe_o=0.
- RST_N asserted mid-word (mode 0, N=16, after 7 bits) → all outputs 0 immediately. After RST_N release, a new 0x00FF frame is received correctly (rx_data_o=0x000000FF).
- Last sample edge coincident with CS rise (CPHA=1 word end, CS raised half SCLK later) → rx_valid_o pulses, frame_err_o stays 0.
